// File: rtl/multi_word_adder_seq.sv
// Streams two WORDS x 4-bit operands LS word first through an external
// 4-bit ripple adder, one word per clock, and assembles the full result.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, carry_in)
//   out_valid/out_ready result handshake (sum, carry_out)
//   adder_a/b/cin       operands driven to the external 4-bit adder
//   adder_sum/cout      result returned by the external 4-bit adder
module multi_word_adder_seq #(
  parameter int WORDS = 4,
  localparam int W    = 4 * WORDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic [3:0]   adder_a,
  output logic [3:0]   adder_b,
  output logic         adder_cin,
  input  logic [3:0]   adder_sum,
  input  logic         adder_cout
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [W-1:0]    sum_d;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            last;

  assign last = (idx_q == IW'(WORDS - 1));

  // Word select onto the adder; zero whenever the sequencer is not in RUN.
  always_comb begin
    adder_a   = 4'd0;
    adder_b   = 4'd0;
    adder_cin = 1'b0;
    if (state_q == RUN) begin
      adder_cin = carry_q;
      for (int k = 0; k < WORDS; k++) begin
        if (idx_q == IW'(k)) begin
          adder_a = a_q[4*k +: 4];
          adder_b = b_q[4*k +: 4];
        end
      end
    end
  end

  // Merge the adder's word result into the assembled sum.
  always_comb begin
    sum_d = sum_q;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IW'(k)) sum_d[4*k +: 4] = adder_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in;
            sum_q   <= '0;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= adder_cout;
          if (last) state_q <= DONE;
          else      idx_q   <= idx_q + 1'b1;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result is only exposed in DONE so partial sums never leak out.
  assign in_ready  = (state_q == IDLE) & ~reset;
  assign out_valid = (state_q == DONE);
  assign sum       = out_valid ? sum_q : '0;
  assign carry_out = out_valid & carry_q;

endmodule

// File: tb/tb_multi_word_adder_seq.sv
// Directed bench for multi_word_adder_seq with WORDS=4 and WORDS=1
// instances, each fed by a behavioural 4-bit adder.
module tb_multi_word_adder_seq;

  logic        clk = 1'b0;
  logic        reset;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // WORDS = 4 instance
  logic        in_valid, in_ready, carry_in, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        carry_out;
  logic [3:0]  adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_cout;

  assign {adder_cout, adder_sum} =
    {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_cin};

  multi_word_adder_seq #(.WORDS(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_sum (adder_sum),
    .adder_cout(adder_cout)
  );

  // WORDS = 1 instance
  logic        v1, r1, ci1, ov1, ordy1, co1;
  logic [3:0]  a1, b1, s1;
  logic [3:0]  aa1, ab1, as1;
  logic        acin1, acout1;

  assign {acout1, as1} = {1'b0, aa1} + {1'b0, ab1} + {4'd0, acin1};

  multi_word_adder_seq #(.WORDS(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v1),
    .in_ready  (r1),
    .a         (a1),
    .b         (b1),
    .carry_in  (ci1),
    .out_valid (ov1),
    .out_ready (ordy1),
    .sum       (s1),
    .carry_out (co1),
    .adder_a   (aa1),
    .adder_b   (ab1),
    .adder_cin (acin1),
    .adder_sum (as1),
    .adder_cout(acout1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer operands, follow the word stream, check the result.
  task automatic run4(input logic [15:0] ta, input logic [15:0] tb,
                      input logic tc, input logic [15:0] es,
                      input logic ec, input logic drain);
    a = ta; b = tb; carry_in = tc; in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = 16'hdead; b = 16'hbeef; carry_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("adder_a_word", adder_a, ta[4*k +: 4]);
      chk("adder_b_word", adder_b, tb[4*k +: 4]);
      chk("run_no_valid", out_valid, 0);
      tick();
    end
    chk("latency_valid", out_valid, 1);
    chk("sum", sum, es);
    chk("carry_out", carry_out, ec);
    if (drain) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("drained", out_valid, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; carry_in = 1'b0;
    out_ready = 1'b0;
    v1 = 1'b1; a1 = 4'h3; b1 = 4'h4; ci1 = 1'b0; ordy1 = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);
    chk("rst_adder_a", adder_a, 0);
    chk("rst_in_ready1", r1, 0);
    in_valid = 1'b0; v1 = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_ready", in_ready, 1);
    chk("idle_adder_cin", adder_cin, 0);

    run4(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
    run4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    run4(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1);

    // Backpressure with a new offer pending
    run4(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    a = 16'h0002; b = 16'h0003; carry_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, 16'h5555);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_released", out_valid, 0);
    chk("bp_ready_back", in_ready, 1);
    run4(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b1);

    // Reset while idx == 2
    a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_run_word2", adder_a, 4'hF);
    reset = 1'b1;
    tick();
    chk("abort_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", carry_out, 0);
    chk("abort_adder_a", adder_a, 0);
    chk("abort_adder_b", adder_b, 0);
    chk("abort_adder_cin", adder_cin, 0);
    reset = 1'b0;
    tick();
    chk("abort_idle", in_ready, 1);
    run4(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b1);

    // WORDS = 1
    a1 = 4'hF; b1 = 4'h1; ci1 = 1'b0; v1 = 1'b1;
    chk("w1_ready", r1, 1);
    tick();
    v1 = 1'b0; a1 = 4'h0;
    chk("w1_adder_a", aa1, 4'hF);
    chk("w1_run_valid", ov1, 0);
    tick();
    chk("w1_valid", ov1, 1);
    chk("w1_sum", s1, 4'h0);
    chk("w1_cout", co1, 1);
    ordy1 = 1'b1;
    tick();
    ordy1 = 1'b0;
    chk("w1_drained", ov1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
